// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle core sequencer: FSM states,
// PC-source selects and ALU operation codes.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd7
   } mc_state_t;

   localparam logic [1:0] PCSEL_P4  = 2'b00;
   localparam logic [1:0] PCSEL_BR  = 2'b01;
   localparam logic [1:0] PCSEL_J   = 2'b10;
   localparam logic [1:0] PCSEL_INT = 2'b11;

   // ALUop is {isRtype, isbranch}; both bits may be set together
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-request watchdog: counts consecutive request cycles without an
// ack and flags the cycle in which the WAIT_MAX-th such cycle ends.
// WAIT_MAX = 0 disables expiry.
module mc_wait_timer #(
   parameter int WAIT_MAX = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic req_nack,
   output logic expired,
   output logic count_zero
);

   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);
   localparam logic [CW-1:0] CNT_SAT  = '1;

   logic [CW-1:0] count_reg;

   // Clear has priority; saturate so a disabled watchdog never wraps to zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (req_nack && (count_reg != CNT_SAT)) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign expired    = (WAIT_MAX != 0) && req_nack && (count_reg == CNT_LAST);
   assign count_zero = (count_reg == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer (fetch/decode/execute/memory/writeback) sharing a
// single memory port between instruction fetch and data access.
// Control outputs are decoded from the registered state plus inputs.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int WAIT_MAX = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        isStype,
   input  logic        isRtype,
   input  logic        isItype,
   input  logic        isLw,
   input  logic        isjump,
   input  logic        isbranch,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  pcSel,
   output logic        RegWrite,
   output logic        Mem2Reg,
   output logic        ALUSrc,
   output logic [1:0]  ALUop,
   output logic [2:0]  state,
   output logic        fault,
   output logic [31:0] retired
);

   mc_state_t   state_reg, state_next;
   logic        fault_reg;
   logic [31:0] retired_reg;
   logic        retire;
   logic        fetch_int;
   logic        wait_clr, wait_nack, wait_expired, wait_zero;

   // An interrupt PC load is only taken before a fetch request has gone out
   assign fetch_int = (state_reg == ST_FETCH) && INT && wait_zero;

   // Request is decoded straight from state so the watchdog has no path
   // through the next-state logic
   assign mem_req   = rst_n && (((state_reg == ST_FETCH) && !fetch_int) ||
                                (state_reg == ST_MEM));
   assign wait_nack = mem_req && !mem_ack;
   assign wait_clr  = (mem_req && mem_ack) ||
                      ((state_next != state_reg) &&
                       ((state_next == ST_FETCH) || (state_next == ST_MEM)));

   mc_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (wait_clr),
      .req_nack   (wait_nack),
      .expired    (wait_expired),
      .count_zero (wait_zero)
   );

   // Next-state and datapath control decode
   always_comb begin
      state_next = state_reg;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      pcSel      = PCSEL_P4;
      RegWrite   = 1'b0;
      Mem2Reg    = 1'b0;
      ALUSrc     = 1'b0;
      ALUop      = ALUOP_ADD;
      retire     = 1'b0;
      case (state_reg)
         ST_FETCH: begin
            if (fetch_int) begin
               PCWrite = 1'b1;
               pcSel   = PCSEL_INT;
            end else begin
               MemRead = 1'b1;
               if (mem_ack) begin
                  IRWrite    = 1'b1;
                  state_next = ST_DECODE;
               end else if (wait_expired) begin
                  state_next = ST_FAULT;
               end
            end
         end
         ST_DECODE: begin
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            ALUSrc = !(isRtype || isbranch);
            ALUop  = (isRtype  ? ALUOP_RTYPE  : ALUOP_ADD) |
                     (isbranch ? ALUOP_BRANCH : ALUOP_ADD);
            if (isbranch) begin
               PCWrite    = 1'b1;
               pcSel      = zero ? PCSEL_BR : PCSEL_P4;
               retire     = 1'b1;
               state_next = ST_FETCH;
            end else if (isjump) begin
               PCWrite    = 1'b1;
               pcSel      = PCSEL_J;
               retire     = 1'b1;
               state_next = ST_FETCH;
            end else if (isLw || isStype) begin
               state_next = ST_MEM;
            end else if (isRtype || isItype) begin
               state_next = ST_WB;
            end else begin
               // unflagged encodings are treated as plain ALU ops
               state_next = ST_WB;
            end
         end
         ST_MEM: begin
            IorD     = 1'b1;
            MemRead  = isLw;
            MemWrite = isStype;
            ALUSrc   = 1'b1;
            if (mem_ack) begin
               if (isLw) begin
                  state_next = ST_WB;
               end else begin
                  PCWrite    = 1'b1;
                  pcSel      = PCSEL_P4;
                  retire     = 1'b1;
                  state_next = ST_FETCH;
               end
            end else if (wait_expired) begin
               state_next = ST_FAULT;
            end
         end
         ST_WB: begin
            RegWrite   = 1'b1;
            Mem2Reg    = isLw;
            PCWrite    = 1'b1;
            pcSel      = PCSEL_P4;
            retire     = 1'b1;
            state_next = ST_FETCH;
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
         default: begin
            state_next = ST_FAULT;
         end
      endcase
      // Reset silences every enable and aborts the instruction in flight
      if (!rst_n) begin
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         pcSel      = PCSEL_P4;
         RegWrite   = 1'b0;
         Mem2Reg    = 1'b0;
         ALUSrc     = 1'b0;
         ALUop      = ALUOP_ADD;
         retire     = 1'b0;
         state_next = ST_FETCH;
      end
   end

   // State, sticky fault flag and retired-instruction counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_FETCH;
         fault_reg   <= 1'b0;
         retired_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_next == ST_FAULT) begin
            fault_reg <= 1'b1;
         end
         if (retire) begin
            retired_reg <= retired_reg + 32'd1;
         end
      end
   end

   assign state   = state_reg;
   assign fault   = fault_reg;
   assign retired = retired_reg;

endmodule
